// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ready handshake
// and resolves the next PC (sequential or BEQ target) once the instruction issues.
module instruction_fetch #(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              branch,
  input  logic              zero,
  output logic [31:0]       instr,
  output logic [2:0]        tipo,
  output logic [2:0]        funct3,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(32'd4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] imm_b_s;
  logic [ADDR_W-1:0] target_s;

  // B-type immediate, sign-extended to the PC width (bit 0 is always zero)
  assign imm_b_s  = {{(ADDR_W-12){instr_q[31]}}, instr_q[7], instr_q[30:25],
                     instr_q[11:8], 1'b0};
  assign target_s = pc_q + imm_b_s;

  // State and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and next-PC resolution
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          valid_d = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (branch && zero) begin
            // A misaligned target is truncated to a word boundary and flagged
            if (target_s[1:0] != 2'b00) begin
              misalign_d = 1'b1;
            end else begin
              misalign_d = misalign_q;
            end
            fetch_pc_d = {target_s[ADDR_W-1:2], 2'b00};
          end else begin
            fetch_pc_d = pc_q + PC_STEP;
          end
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = fetch_pc_q;
  assign instr        = instr_q;
  assign tipo         = instr_q[6:4];
  assign funct3       = instr_q[14:12];
  assign instr_valid  = valid_q;
  assign pc           = pc_q;
  assign misalign_err = misalign_q;

endmodule
